demux1_4_sched: RTL and testbench

//  Round-robin / directed dispatcher sharing one upstream stream among four consumers.

---
 rtl/demux1_4_sched_pkg.sv | 14 +
 rtl/demux1_4_sched_sub.sv | 42 ++++
 rtl/demux1_4_sched.sv | 134 +++++++++++++
 tb/tb_demux1_4_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux1_4_sched_pkg.sv
// Shared types and encodings for the 1:4 stream dispatcher.
// FSM state codes and dispatch-mode constants used across the block.
package demux1_4_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_DIR = 1'b1;

endpackage

// File: rtl/demux1_4_sched_sub.sv
// Combinational helpers for the dispatcher: round-robin lane picker and
// the gate-level 1:4 demultiplexer that produces the per-lane valids.
module rr_pick4 (
  input  logic [3:0] en,
  input  logic [1:0] start,
  output logic [1:0] idx,
  output logic       found
);

  logic [1:0] cand;

  always_comb begin
    idx   = 2'd0;
    found = 1'b0;
    cand  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = start + 2'(k);
      if (!found && en[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

module demux1_4 (
  input  logic d,
  input  logic s0,
  input  logic s1,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);

  assign y0 = d & ~s1 & ~s0;
  assign y1 = d & ~s1 &  s0;
  assign y2 = d &  s1 & ~s0;
  assign y3 = d &  s1 &  s0;

endmodule

// File: rtl/demux1_4_sched.sv
// Dispatcher sharing one upstream valid/ready stream among four consumer lanes,
// either round-robin over enabled lanes or directed by the word's destination.
//
// state  | meaning
// S_IDLE | in_ready high, waiting for an upstream word
// S_ARB  | word held, choosing a lane (one cycle, or longer while no lane is enabled)
// S_XFER | word offered on lane sel until that lane is ready or the wait times out
module demux1_4_sched
  import demux1_4_sched_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  input  logic              mode,
  input  logic [3:0]        en,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t            state, state_nxt;
  logic [1:0]        ptr, ptr_nxt;
  logic [1:0]        sel_nxt;
  logic [DATA_W-1:0] hold_data, hold_data_nxt;
  logic [1:0]        hold_dest, hold_dest_nxt;
  logic [CW-1:0]     wait_cnt, wait_cnt_nxt;
  logic              drop;
  logic [1:0]        pick_idx;
  logic              pick_found;

  rr_pick4 u_pick (
    .en    (en),
    .start (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= 2'd0;
      sel       <= 2'd0;
      hold_data <= '0;
      hold_dest <= 2'd0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      sel       <= sel_nxt;
      hold_data <= hold_data_nxt;
      hold_dest <= hold_dest_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    sel_nxt       = sel;
    hold_data_nxt = hold_data;
    hold_dest_nxt = hold_dest;
    wait_cnt_nxt  = wait_cnt;
    drop          = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          hold_data_nxt = in_data;
          hold_dest_nxt = in_dest;
          state_nxt     = S_ARB;
        end
      end
      S_ARB: begin
        if (mode == MODE_DIR) begin
          if (en[hold_dest]) begin
            sel_nxt      = hold_dest;
            wait_cnt_nxt = '0;
            state_nxt    = S_XFER;
          end else begin
            drop      = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (pick_found) begin
          sel_nxt      = pick_idx;
          wait_cnt_nxt = '0;
          state_nxt    = S_XFER;
        end
      end
      S_XFER: begin
        if (out_ready[sel]) begin
          ptr_nxt   = sel + 2'd1;
          state_nxt = S_IDLE;
        end else begin
          if (wait_cnt != CNT_MAX) wait_cnt_nxt = wait_cnt + CNT_ONE;
          // Only round-robin words may move to another lane; directed words wait forever.
          if (mode == MODE_RR && TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
            ptr_nxt   = sel + 2'd1;
            state_nxt = S_ARB;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_ready = (state == S_IDLE) && !rst;
  assign busy     = (state != S_IDLE);
  assign err      = drop && !rst;
  assign out_data = hold_data;

  demux1_4 u_demux (
    .d  ((state == S_XFER) && !rst),
    .s0 (sel[0]),
    .s1 (sel[1]),
    .y0 (out_valid[0]),
    .y1 (out_valid[1]),
    .y2 (out_valid[2]),
    .y3 (out_valid[3])
  );

endmodule

// File: tb/tb_demux1_4_sched.sv
// Self-checking bench for demux1_4_sched: directed scenarios plus randomized
// words checked against a transaction-level lane-selection model.
module tb_demux1_4_sched;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_dest;
  logic              mode;
  logic [3:0]        en;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [1:0]        sel;
  logic              busy;
  logic              err;

  int n_chk  = 0;
  int n_pass = 0;
  int model_ptr = 0;

  demux1_4_sched #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .mode      (mode),
    .en        (en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Lane a round-robin word lands on: first enabled lane starting at the pointer.
  function automatic int rr_target(input int p, input logic [3:0] ev);
    for (int k = 0; k < 4; k++)
      if (ev[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int lane);
    return 32'(1) << lane;
  endfunction

  task automatic run_word(input logic [7:0] d, input logic [1:0] dst, input logic md,
                          input logic [3:0] ev, input int delay, input bit noise);
    int lane;
    chk("idle_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_dest = dst; mode = md; en = ev; out_ready = 4'd0;
    tick();
    in_valid = noise; in_data = 8'($urandom); in_dest = 2'($urandom);
    chk("arb_busy", 32'(busy), 32'd1);
    chk("arb_ready", 32'(in_ready), 32'd0);
    chk("arb_valid", 32'(out_valid), 32'd0);
    if (md && !ev[dst]) begin
      chk("err_pulse", 32'(err), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("err_clear", 32'(err), 32'd0);
      chk("drop_idle", 32'(busy), 32'd0);
      chk("drop_valid", 32'(out_valid), 32'd0);
      chk("drop_ready", 32'(in_ready), 32'd1);
      return;
    end
    chk("arb_noerr", 32'(err), 32'd0);
    lane = md ? int'(dst) : rr_target(model_ptr, ev);
    tick();
    chk("xfer_sel", 32'(sel), 32'(lane));
    chk("xfer_valid", 32'(out_valid), onehot(lane));
    chk("xfer_data", 32'(out_data), 32'(d));
    if (noise) begin mode = 1'($urandom); en = 4'($urandom); end
    for (int k = 0; k < delay; k++) begin
      out_ready = 4'($urandom) & ~(4'b1 << lane);
      tick();
      chk("wait_valid", 32'(out_valid), onehot(lane));
      chk("wait_data", 32'(out_data), 32'(d));
    end
    out_ready = (4'b1 << lane) | 4'($urandom);
    tick();
    in_valid = 1'b0; out_ready = 4'd0;
    chk("done_idle", 32'(busy), 32'd0);
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_ready", 32'(in_ready), 32'd1);
    model_ptr = (lane + 1) % 4;
  endtask

  initial begin
    int lane;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = 2'd0;
    mode = 1'b0; en = 4'd0; out_ready = 4'd0;
    @(negedge clk);
    tick();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_sel", 32'(sel), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Round robin over all lanes
    for (int i = 0; i < 4; i++) run_word(8'hA0 + 8'(i), 2'd0, 1'b0, 4'b1111, 0, 1'b0);
    // Sparse enable mask, pointer wrap
    for (int i = 0; i < 3; i++) run_word(8'h50 + 8'(i), 2'd0, 1'b0, 4'b1010, i, 1'b0);
    // Directed word to a disabled lane is dropped
    run_word(8'h33, 2'd2, 1'b1, 4'b1011, 0, 1'b0);
    run_word(8'h34, 2'd3, 1'b1, 4'b1011, 1, 1'b0);

    // Timeout re-arbitration
    mode = 1'b0; en = 4'b0011; out_ready = 4'd0;
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    lane = rr_target(model_ptr, 4'b0011);
    tick();
    chk("to_sel0", 32'(sel), 32'(lane));
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      chk("to_wait", 32'(out_valid), onehot(lane));
    end
    tick();
    chk("to_arb_valid", 32'(out_valid), 32'd0);
    chk("to_arb_busy", 32'(busy), 32'd1);
    chk("to_arb_ready", 32'(in_ready), 32'd0);
    model_ptr = (lane + 1) % 4;
    lane = rr_target(model_ptr, 4'b0011);
    tick();
    chk("to_sel1", 32'(sel), 32'(lane));
    chk("to_valid1", 32'(out_valid), onehot(lane));
    chk("to_data", 32'(out_data), 32'h5A);
    out_ready = 4'b1 << lane;
    tick();
    out_ready = 4'd0;
    chk("to_done", 32'(busy), 32'd0);
    model_ptr = (lane + 1) % 4;

    // Reset in the middle of a transfer
    mode = 1'b0; en = 4'b1111;
    in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    lane = rr_target(model_ptr, 4'b1111);
    tick();
    chk("rx_valid", 32'(out_valid), onehot(lane));
    rst = 1'b1;
    tick();
    chk("rx_valid_off", 32'(out_valid), 32'd0);
    chk("rx_sel", 32'(sel), 32'd0);
    chk("rx_busy", 32'(busy), 32'd0);
    chk("rx_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    model_ptr = 0;
    tick();
    run_word(8'h11, 2'd0, 1'b0, 4'b1111, 0, 1'b0);

    // No lane enabled: word parks in arbitration
    mode = 1'b0; en = 4'b0000;
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("park_busy", 32'(busy), 32'd1);
      chk("park_ready", 32'(in_ready), 32'd0);
      chk("park_valid", 32'(out_valid), 32'd0);
      tick();
    end
    en = 4'b0100;
    tick();
    chk("park_sel", 32'(sel), 32'd2);
    chk("park_xfer", 32'(out_valid), 32'b0100);
    chk("park_data", 32'(out_data), 32'h77);
    out_ready = 4'b0100;
    tick();
    out_ready = 4'd0;
    chk("park_done", 32'(busy), 32'd0);
    model_ptr = 3;

    // Randomized words against the model
    for (int i = 0; i < 60; i++) begin
      logic       md;
      logic [3:0] ev;
      md = 1'($urandom);
      ev = 4'($urandom);
      if (!md && ev == 4'd0) ev = 4'b0001 << $urandom_range(0, 3);
      run_word(8'($urandom), 2'($urandom), md, ev, $urandom_range(0, 5), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
